// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer slice.
// Holds the phase encoding and the widths of the lives/time/score datapath.
package game_pkg;

  localparam int LIVES_W = 2;
  localparam int TIME_W  = 9;
  localparam int SCORE_W = 14;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    GAMEOVER = 3'd3,
    WON      = 3'd4
  } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of the sequencer's event inputs and phase/datapath outputs.
//   slave  : the sequencer (consumes events, drives state/freeze/respawn/lives/g_time/score)
//   master : the surrounding game logic (drives events, observes the outputs)
interface game_sequencer_if;
  import game_pkg::*;

  logic               tick_60hz;
  logic               start_b;
  logic               outbounds;
  logic               game_win;
  logic               coin_det;
  logic [2:0]         state;
  logic               freeze;
  logic               respawn;
  logic [LIVES_W-1:0] lives;
  logic [TIME_W-1:0]  g_time;
  logic [SCORE_W-1:0] score;

  modport slave (
    input  tick_60hz, start_b, outbounds, game_win, coin_det,
    output state, freeze, respawn, lives, g_time, score
  );

  modport master (
    output tick_60hz, start_b, outbounds, game_win, coin_det,
    input  state, freeze, respawn, lives, g_time, score
  );

endinterface

// File: rtl/game_sequencer_rise_detect.sv
// Rising-edge detector: remembers last cycle's level and flags a 0->1 change.
//   clk, rst : clock and asynchronous active-high reset (history clears to 0)
//   level    : synchronous input level
//   pulse    : high for one cycle when level is 1 and was 0 on the previous cycle
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Game-phase controller: sequences IDLE/PLAY/DYING/GAMEOVER/WON and owns the
// lives counter, countdown timer and score.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of game_sequencer_if
//              in : tick_60hz, start_b, outbounds, game_win, coin_det
//              out: state, freeze, respawn, lives, g_time, score (all registered)
module game_sequencer
  import game_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int GAME_TIME     = 300,
  parameter int TICKS_PER_SEC = 60,
  parameter int DEATH_HOLD    = 90,
  parameter int COIN_POINTS   = 10,
  parameter int SCORE_MAX     = 9999
) (
  input logic              clk,
  input logic              rst,
  game_sequencer_if.slave  bus
);

  localparam int SUB_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HOLD_W = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEATH_HOLD - 1);

  state_t             state;
  logic               freeze;
  logic               respawn;
  logic [LIVES_W-1:0] lives;
  logic [TIME_W-1:0]  g_time;
  logic [SCORE_W-1:0] score;
  logic [SUB_W-1:0]   sub_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               start_rise;
  logic               coin_rise;

  rise_detect u_start_rd (.clk(clk), .rst(rst), .level(bus.start_b),  .pulse(start_rise));
  rise_detect u_coin_rd  (.clk(clk), .rst(rst), .level(bus.coin_det), .pulse(coin_rise));

  function automatic logic [SCORE_W-1:0] add_coin(input logic [SCORE_W-1:0] s);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(COIN_POINTS);
    if (sum > (SCORE_W+1)'(SCORE_MAX)) return SCORE_W'(SCORE_MAX);
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [LIVES_W-1:0] lose_life(input logic [LIVES_W-1:0] l);
    if (l == '0) return '0;
    return l - LIVES_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      freeze   <= 1'b1;
      respawn  <= 1'b0;
      lives    <= '0;
      g_time   <= '0;
      score    <= '0;
      sub_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      respawn <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state   <= PLAY;
            freeze  <= 1'b0;
            respawn <= 1'b1;
            lives   <= LIVES_W'(START_LIVES);
            g_time  <= TIME_W'(GAME_TIME);
            score   <= '0;
            sub_cnt <= '0;
          end
        end
        PLAY: begin
          // Coins score even on the cycle PLAY is being left.
          if (coin_rise) score <= add_coin(score);
          // Win beats death; the timer only advances when no event fires.
          if (bus.game_win) begin
            state  <= WON;
            freeze <= 1'b1;
          end else if (bus.outbounds) begin
            state    <= DYING;
            freeze   <= 1'b1;
            lives    <= lose_life(lives);
            hold_cnt <= '0;
          end else if (bus.tick_60hz) begin
            if (sub_cnt == SUB_LAST) begin
              sub_cnt <= '0;
              g_time  <= g_time - TIME_W'(1);
              if (g_time == TIME_W'(1)) begin
                state    <= DYING;
                freeze   <= 1'b1;
                lives    <= lose_life(lives);
                hold_cnt <= '0;
              end
            end else begin
              sub_cnt <= sub_cnt + SUB_W'(1);
            end
          end
        end
        DYING: begin
          if (bus.tick_60hz) begin
            if (hold_cnt == HOLD_LAST) begin
              if (lives == '0) begin
                state <= GAMEOVER;
              end else begin
                state   <= PLAY;
                freeze  <= 1'b0;
                respawn <= 1'b1;
                g_time  <= TIME_W'(GAME_TIME);
                sub_cnt <= '0;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        GAMEOVER, WON: begin
          if (start_rise) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          freeze <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state   = state;
  assign bus.freeze  = freeze;
  assign bus.respawn = respawn;
  assign bus.lives   = lives;
  assign bus.g_time  = g_time;
  assign bus.score   = score;

endmodule
